// File: rtl/fifo_burst_writer_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_writer_if
// Groups the two data paths around the burst writer into a single bundle:
//   upstream stream : s_data, s_valid, s_last (into the writer), s_ready (out)
//   FIFO write port : fifo_data, fifo_write (out of the writer),
//                     fifo_full, fifo_usedw (FIFO status into the writer)
// Modports:
//   master - the burst writer itself
//   slave  - the surrounding environment (upstream source plus FIFO)
// -----------------------------------------------------------------------------
interface fifo_burst_writer_if #(
  parameter int WIDTH  = 16,
  parameter int UWIDTH = 5
);

  logic [WIDTH-1:0]  s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  logic [WIDTH-1:0]  fifo_data;
  logic              fifo_write;
  logic              fifo_full;
  logic [UWIDTH-1:0] fifo_usedw;

  modport master (
    input  s_data, s_valid, s_last, fifo_full, fifo_usedw,
    output s_ready, fifo_data, fifo_write
  );

  modport slave (
    output s_data, s_valid, s_last, fifo_full, fifo_usedw,
    input  s_ready, fifo_data, fifo_write
  );

endinterface

// File: rtl/fifo_burst_writer.sv
// -----------------------------------------------------------------------------
// fifo_burst_writer
// Moves an upstream valid/ready stream into the write port of a dual-clock
// FIFO in bursts of at most BURST words. A burst is only admitted when the
// FIFO has room for the whole burst plus the one word that may still be sitting
// in the output register, so the writer never needs to look at fifo_full while
// streaming.
// Ports:
//   rst      - asynchronous, active-high reset
//   clkw     - write-side clock, all logic runs on it
//   bus      - fifo_burst_writer_if.master (upstream stream + FIFO write port)
//   busy     - high while a burst is in progress
//   bursts   - count of completed bursts, wraps at 16 bits
//   overflow - sticky flag, set when a write is presented to a full FIFO
// -----------------------------------------------------------------------------
module fifo_burst_writer #(
  parameter int WIDTH  = 16,
  parameter int SIZE   = 32,
  parameter int BURST  = 8,
  parameter int UWIDTH = $clog2(SIZE)
) (
  input  logic                rst,
  input  logic                clkw,
  fifo_burst_writer_if.master bus,
  output logic                busy,
  output logic [15:0]         bursts,
  output logic                overflow
);

  // Guard the width below so an illegal BURST reports the error message
  // instead of tripping over a zero-width counter first.
  localparam int CW = (BURST < 1) ? 1 : $clog2(BURST + 1);

  localparam logic [UWIDTH:0] MAX_FREE = (UWIDTH + 1)'(SIZE - 1);
  localparam logic [UWIDTH:0] NEED     = (UWIDTH + 1)'(BURST + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(BURST - 1);

  if (BURST < 1 || BURST > SIZE - 2 || SIZE < 8) begin : g_param_check
    $error("fifo_burst_writer: SIZE must be >= 8 and BURST must lie in 1..SIZE-2");
  end

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      bursts_q, bursts_d;
  logic             fifo_write_q;
  logic [WIDTH-1:0] fifo_data_q;
  logic             overflow_q;

  logic [UWIDTH:0]  free;
  logic             acc;

  // Free space seen from the write side; one slot is kept in reserve because
  // a FIFO of SIZE entries reports at most SIZE-1 usable words here.
  assign free = MAX_FREE - {1'b0, bus.fifo_usedw};

  // Ready comes straight from the state register so the upstream source never
  // sees a combinational loop through its own valid.
  assign bus.s_ready = (state_q == ST_BURST);
  assign acc         = bus.s_valid & bus.s_ready;

  assign busy           = (state_q == ST_BURST);
  assign bursts         = bursts_q;
  assign overflow       = overflow_q;
  assign bus.fifo_write = fifo_write_q;
  assign bus.fifo_data  = fifo_data_q;

  // Admission and burst termination. A burst ends either when it has taken
  // BURST words or when the packet ends early; both conditions on the same
  // word still count as a single completed burst.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bursts_d = bursts_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.s_valid && (free >= NEED)) begin
          state_d = ST_BURST;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (acc) begin
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q == LAST_CNT) || bus.s_last) begin
            state_d  = ST_IDLE;
            bursts_d = bursts_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and the registered FIFO write port. The output register
  // adds one cycle between accept and write strobe; on reset an accepted word
  // still held here is simply dropped.
  always_ff @(posedge clkw or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bursts_q     <= '0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bursts_q     <= bursts_d;
      fifo_write_q <= acc;
      if (acc) begin
        fifo_data_q <= bus.s_data;
      end
      // The write is still presented; the FIFO drops it on its own, we only
      // remember that it happened.
      if (fifo_write_q && bus.fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter SIZE, default 32, depth of the downstream dual-clock FIFO; legal range 8 and above.
REQ-003 SHALL have parameter BURST, default 8, maximum words per admitted burst; legal range 1 to SIZE-2.
REQ-004 SHALL have parameter UWIDTH, default $clog2(SIZE), width of the FIFO fill level.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port clkw, input, 1, clock; all logic is on clkw.
REQ-007 SHALL have port s_data, input, WIDTH, upstream data.
REQ-008 SHALL have port s_valid, input, 1, upstream word valid.
REQ-009 SHALL have port s_last, input, 1, marks the final word of an upstream packet.
REQ-010 SHALL have port s_ready, output, 1, upstream word accepted when s_valid and s_ready are both high.
REQ-011 SHALL have port fifo_data, output, WIDTH, data to the FIFO write port.
REQ-012 SHALL have port fifo_write, output, 1, FIFO write strobe.
REQ-013 SHALL have port fifo_full, input, 1, FIFO full flag.
REQ-014 SHALL have port fifo_usedw, input, UWIDTH, FIFO write-side fill level.
REQ-015 SHALL have port busy, output, 1, high while state is BURST.
REQ-016 SHALL have port bursts, output, 16, count of completed bursts; wraps at 65535 -> 0.
REQ-017 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-018 SHALL raise an elaboration error when BURST < 1, when BURST > SIZE-2, or when SIZE < 8.
REQ-019 SHALL compute free = (SIZE-1) - fifo_usedw, unsigned, at UWIDTH+1 bits.
REQ-020 SHALL implement a two-state FSM with states IDLE and BURST, plus word counter cnt, width $clog2(BURST+1).
REQ-021 SHALL move IDLE -> BURST on the clock edge where s_valid=1 and free >= BURST+1, clearing cnt to 0 on that edge.
- The +1 margin covers the one write in flight in the output register.
REQ-022 SHALL hold IDLE while free < BURST+1, regardless of s_valid.
REQ-023 SHALL drive s_ready = (state == BURST), combinationally from the state register only, with no path from s_valid.
REQ-024 SHALL define acc = s_valid & s_ready; on each acc, cnt increments by 1.
REQ-025 SHALL move BURST -> IDLE on the edge where acc=1 and either cnt == BURST-1 or s_last=1.
- On that same edge, bursts increments by 1.
REQ-026 SHALL keep state and cnt unchanged in BURST while s_valid=0; there is no timeout.
REQ-027 SHALL register the FIFO outputs: fifo_write <= acc and fifo_data <= s_data when acc=1; fifo_data holds its value otherwise.
- Latency is 1 clkw cycle from accept to write strobe.
REQ-028 SHALL never write more than BURST words per admission, so the minimum gap between bursts is one IDLE cycle.
- Peak throughput is BURST / (BURST+1).
REQ-029 SHALL set overflow on any edge where fifo_write=1 and fifo_full=1; overflow clears only on rst.
- The write is still presented to the FIFO, which drops it under its own protection.
REQ-030 SHALL accept s_last on a word that is not at a burst boundary; the next packet then starts a new admission.
REQ-031 SHALL treat s_last coinciding with cnt == BURST-1 as a single burst end, with one bursts increment.

Reset
REQ-032 SHALL asynchronously force on rst=1: state=IDLE, cnt=0, s_ready=0, busy=0, fifo_write=0, fifo_data=0, bursts=0, overflow=0.
REQ-033 SHALL discard a partial burst on reset mid-burst: no further fifo_write after rst rises, and any accepted word not yet written is lost.
REQ-034 SHALL make the first admission possible on the first clkw edge after rst falls.

Verification
REQ-035 Empty FIFO (usedw=0), 8-word packet with s_valid held high, SIZE=32, BURST=8 -> s_ready high cycles 1-8, fifo_write high cycles 2-9, bursts=1, busy low at cycle 9.
REQ-036 usedw=23 (free=8), s_valid=1 -> s_ready stays 0; usedw drops to 22 -> BURST entered on the next edge.
REQ-037 20-word packet on empty FIFO -> three bursts of 8, 8 and 4 words, one IDLE cycle between them, bursts=3, last write coincides with s_last.
REQ-038 s_valid toggled 1-0-1 inside a burst -> cnt holds across gaps; 8 writes total, each matching the accepted s_data in order.
REQ-039 Force fifo_full=1 while fifo_write=1 -> overflow=1 on the next edge, stays 1 afterwards, clears only after an rst pulse.
REQ-040 rst asserted after 3 of 8 words accepted -> fifo_write=0 immediately, bursts=0; post-reset usedw=0 -> new burst admitted.
